// File: rtl/bitty_fetch_sequencer_if.sv
// Memory and core-side signal bundle for the bitty fetch sequencer.
// The sequencer is the master; memory and core responders sit on the slave side.
interface bitty_fetch_sequencer_if #(
  parameter int ADDR_W = 8
) ();
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [15:0]       mem_rdata;
  logic              mem_valid;
  logic [15:0]       core_instruction;
  logic              core_run;
  logic              core_done;

  modport master (
    output mem_addr, mem_rd, core_instruction, core_run,
    input  mem_rdata, mem_valid, core_done
  );

  modport slave (
    input  mem_addr, mem_rd, core_instruction, core_run,
    output mem_rdata, mem_valid, core_done
  );
endinterface

// File: rtl/bitty_fetch_sequencer.sv
// Autonomous fetch/issue sequencer: walks the program counter through
// instruction memory and hands each word to bitty_core via run/done.
module bitty_fetch_sequencer #(
  parameter int          ADDR_W       = 8,
  parameter logic [15:0] HALT_WORD    = 16'hFFFF,
  parameter int          DONE_TIMEOUT = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop,
  bitty_fetch_sequencer_if.master bus,
  output logic                   busy,
  output logic                   halted,
  output logic                   timeout_err,
  output logic [ADDR_W-1:0]      pc,
  output logic [15:0]            instr_count
);

  localparam int TW = $clog2(DONE_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT_MEM, ISSUE, EXEC, HALT, ERROR
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc_n;
  logic [15:0]       instr_q, instr_n;
  logic [15:0]       cnt_n;
  logic              stop_q, stop_n;
  logic [TW-1:0]     tcnt, tcnt_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      pc          <= '0;
      instr_q     <= '0;
      instr_count <= '0;
      stop_q      <= 1'b0;
      tcnt        <= '0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      instr_q     <= instr_n;
      instr_count <= cnt_n;
      stop_q      <= stop_n;
      tcnt        <= tcnt_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    instr_n = instr_q;
    cnt_n   = instr_count;
    stop_n  = stop_q;
    tcnt_n  = tcnt;
    if (busy && stop) stop_n = 1'b1;
    unique case (state)
      IDLE, HALT, ERROR: begin
        if (start) begin
          state_n = FETCH;
          pc_n    = '0;
          cnt_n   = '0;
          stop_n  = 1'b0;
        end
      end
      FETCH: state_n = WAIT_MEM;
      WAIT_MEM: begin
        if (bus.mem_valid) begin
          if (bus.mem_rdata == HALT_WORD) begin
            state_n = HALT;
          end else begin
            instr_n = bus.mem_rdata;
            state_n = ISSUE;
          end
        end
      end
      ISSUE: begin
        tcnt_n  = '0;
        state_n = EXEC;
      end
      EXEC: begin
        // done on the final timeout cycle still completes normally
        if (bus.core_done) begin
          if (instr_count != 16'hFFFF) cnt_n = instr_count + 16'd1;
          if (stop_q || stop || pc == '1) begin
            state_n = HALT;
          end else begin
            pc_n    = pc + ADDR_W'(1);
            state_n = FETCH;
          end
        end else if (tcnt == TW'(DONE_TIMEOUT - 1)) begin
          state_n = ERROR;
        end else begin
          tcnt_n = tcnt + TW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy        = (state == FETCH) || (state == WAIT_MEM) ||
                       (state == ISSUE) || (state == EXEC);
  assign halted      = (state == HALT);
  assign timeout_err = (state == ERROR);

  assign bus.mem_addr         = pc;
  assign bus.mem_rd           = (state == FETCH);
  assign bus.core_run         = (state == ISSUE);
  assign bus.core_instruction = instr_q;

endmodule

// File: doc/bitty_fetch_sequencer.md
Name: bitty_fetch_sequencer

Overview:
Autonomous instruction sequencer for the bitty datapath core. It owns a program counter and fetches 16-bit words from a synchronous instruction memory. For each word it presents the instruction to the core, pulses run, and waits for done. It stops on a HALT word, on a stop request, at the end of the address space, or on a done-timeout. It sits between the program memory and bitty_core, replacing manual run/instruction driving.

Parameters:
ADDR_W, 8, program counter / memory address width
HALT_WORD, 16'hFFFF, fetched word that terminates the program (never issued to core)
DONE_TIMEOUT, 32, max EXEC cycles waiting for core_done before error (>=2)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  begin program at address 0 (accepted in IDLE, HALT, ERROR only)
stop  in  1  request halt at next instruction boundary
mem_addr  out  ADDR_W  instruction memory address (= pc)
mem_rd  out  1  one-cycle read strobe
mem_rdata  in  16  memory read data
mem_valid  in  1  mem_rdata valid; sampled only in WAIT_MEM
core_instruction  out  16  registered instruction to bitty_core
core_run  out  1  one-cycle run pulse to bitty_core
core_done  in  1  completion from bitty_core; sampled only in EXEC
busy  out  1  high in FETCH, WAIT_MEM, ISSUE, EXEC
halted  out  1  high in HALT
timeout_err  out  1  high in ERROR
pc  out  ADDR_W  current program counter
instr_count  out  16  instructions completed since last start, saturates at 16'hFFFF

Behaviour:
- Reset (reset=0, async): state IDLE; pc=0, mem_rd=0, core_run=0, core_instruction=0, instr_count=0, stop_pending=0, timeout counter=0; busy/halted/timeout_err=0. Asserting reset mid-operation aborts immediately; no further strobes are issued.
- All outputs are registered or decoded from the state register; no combinational path from any input to any output.
- States: IDLE, FETCH, WAIT_MEM, ISSUE, EXEC, HALT, ERROR.
- IDLE/HALT/ERROR + start=1 -> FETCH; pc=0, instr_count=0, stop_pending=0. A stop in the same cycle is ignored.
- FETCH: mem_rd=1, mem_addr=pc for exactly one cycle -> WAIT_MEM.
- WAIT_MEM: holds until mem_valid=1, with no limit. Capture mem_rdata into core_instruction only if it is not HALT_WORD, then -> ISSUE. If mem_rdata==HALT_WORD -> HALT; core_instruction and pc are unchanged. Memory latency >=1 cycle; mem_valid in the FETCH cycle is ignored.
- ISSUE: core_run=1 for one cycle; timeout counter cleared -> EXEC.
- EXEC: core_instruction held stable. On core_done=1: instr_count+1 (saturating). Then:
  - if stop_pending, or pc == 2^ADDR_W-1, -> HALT with pc unchanged;
  - else pc+1 -> FETCH.
- EXEC without done: counter increments each cycle. The cycle the counter reaches DONE_TIMEOUT-1 with core_done=0 -> ERROR. core_done on that same cycle wins and completes normally.
- stop=1 in any busy state sets stop_pending (sticky until next start). Stop never interrupts a fetch or an executing instruction; the current instruction completes first.
- HALT/ERROR: hold all registers. halted or timeout_err stays high until start or reset.
- core_done outside EXEC and mem_valid outside WAIT_MEM are ignored.
- Minimum per-instruction cost with 1-cycle memory and done the cycle after run: FETCH, WAIT_MEM, ISSUE, EXEC = 4 cycles.

Test Plan:
- Reset then start, mem[0..2]={16'h0421,16'h1A03,16'hFFFF}, memory latency 1, done 2 cycles after run -> two core_run pulses carrying 16'h0421 then 16'h1A03; halted=1, pc=2, instr_count=2, core_instruction=16'h1A03.
- stop pulsed during EXEC of address 0 (program of 5 non-halt words) -> instruction 0 completes; HALT with pc=0, instr_count=1; no further mem_rd.
- core_done held low after run, DONE_TIMEOUT=32 -> ERROR exactly 32 cycles after entering EXEC; timeout_err=1, busy=0. Subsequent start clears the error and fetches address 0.
- ADDR_W=2, all four words non-halt -> four instructions execute; HALT with pc=3, instr_count=4; no wrap to 0.
- mem_valid delayed 5 cycles -> FETCH strobe is one cycle; core_run is not asserted until the cycle after mem_valid; spurious core_done pulses during WAIT_MEM have no effect.
- reset deasserted-asserted mid-EXEC -> all outputs return to reset values asynchronously; after release, state IDLE and start is required to resume.
